// File: rtl/bpu_bht_if.sv
// IF-stage predictor bus: fetch pc/ir in, predictions out,
// plus the ID-stage resolution channel that trains the table.
interface bpu_bht_if #(
  parameter int GW = 1
);
  logic [63:0]   pc;
  logic [31:0]   ir;
  logic          stall;
  logic          jal_taken;
  logic [63:0]   jal_addr;
  logic          pr_taken;
  logic [12:0]   pr_offs;
  logic [GW-1:0] pr_ghr;
  logic          upd_valid;
  logic [63:0]   upd_pc;
  logic [GW-1:0] upd_ghr;
  logic          upd_taken;
  logic          upd_miss;

  modport master (
    output pc, ir, stall,
    output upd_valid, upd_pc, upd_ghr,
    output upd_taken, upd_miss,
    input  jal_taken, jal_addr,
    input  pr_taken, pr_offs, pr_ghr
  );

  modport slave (
    input  pc, ir, stall,
    input  upd_valid, upd_pc, upd_ghr,
    input  upd_taken, upd_miss,
    output jal_taken, jal_addr,
    output pr_taken, pr_offs, pr_ghr
  );
endinterface

// File: rtl/bpu_bht.sv
// Dynamic branch predictor: saturating-counter table with
// optional gshare indexing and a speculative, repairable GHR.
module bpu_bht #(
  parameter int BHT_IDX_W = 6,
  parameter int GHR_W     = 0,
  parameter int CNT_W     = 2,
  parameter int CNT_INIT  = 1
) (
  input logic     clk,
  input logic     rst_n,
  bpu_bht_if.slave bus
);
  localparam int GW = (GHR_W > 0) ? GHR_W : 1;
  localparam int N  = 1 << BHT_IDX_W;
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] CINIT = CNT_W'(CNT_INIT);

  logic [CNT_W-1:0]     cnt [N];
  logic [GW-1:0]        ghr;
  logic                 is_br;
  logic                 is_jal;
  logic                 pr_tk;
  logic [BHT_IDX_W-1:0] pc_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic                 unused;

  assign is_br   = bus.ir[6:0] == 7'b1100011;
  assign is_jal  = bus.ir[6:0] == 7'b1101111;
  assign pc_idx  = bus.pc[BHT_IDX_W+1:2];
  assign upd_idx = bus.upd_pc[BHT_IDX_W+1:2];
  assign unused  = ^{bus.upd_pc[63:BHT_IDX_W+2],
                     bus.upd_pc[1:0]};

  // Direction read: pre-update value, no write bypass.
  assign pr_tk = rst_n & is_br & cnt[rd_idx][CNT_W-1];

  assign bus.pr_taken  = pr_tk;
  assign bus.pr_ghr    = ghr;
  assign bus.jal_taken = rst_n & is_jal;
  assign bus.pr_offs   = is_br
    ? {bus.ir[31], bus.ir[7], bus.ir[30:25],
       bus.ir[11:8], 1'b0}
    : 13'd0;
  assign bus.jal_addr  = bus.pc +
    {{43{bus.ir[31]}}, bus.ir[31], bus.ir[19:12],
     bus.ir[20], bus.ir[30:21], 1'b0};

  generate
    if (GHR_W > 0) begin : g_gshare
      assign rd_idx = pc_idx ^ BHT_IDX_W'(ghr);
      assign wr_idx = upd_idx ^ BHT_IDX_W'(bus.upd_ghr);

      // Mispredict repair wins over the speculative shift.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (bus.upd_valid && bus.upd_miss) begin
          ghr <= GW'({bus.upd_ghr, bus.upd_taken});
        end else if (!bus.stall && is_br) begin
          ghr <= GW'({ghr, pr_tk});
        end
      end
    end else begin : g_bimodal
      logic unused_bim;
      assign rd_idx     = pc_idx;
      assign wr_idx     = upd_idx;
      assign ghr        = '0;
      assign unused_bim = ^{bus.stall, bus.upd_ghr,
                            bus.upd_miss};
    end
  endgenerate

  // Train one counter per resolved branch, saturating both ways.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= CINIT;
    end else if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        if (cnt[wr_idx] != CMAX)
          cnt[wr_idx] <= cnt[wr_idx] + 1'b1;
      end else if (cnt[wr_idx] != '0) begin
        cnt[wr_idx] <= cnt[wr_idx] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bpu_bht.sv
// Bench for bpu_bht: bimodal instance plus a GHR_W=4 gshare
// instance, checked through an expectation scoreboard.
module tb_bpu_bht;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  bpu_bht_if #(.GW(1)) b0 ();
  bpu_bht_if #(.GW(4)) b1 ();

  bpu_bht u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  bpu_bht #(.GHR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] obs(int s);
    case (s)
      0: return 64'(b0.pr_taken);
      1: return 64'(b0.pr_offs);
      2: return 64'(b0.jal_taken);
      3: return b0.jal_addr;
      4: return 64'(b1.pr_taken);
      5: return 64'(b1.pr_ghr);
      6: return 64'(b0.pr_ghr);
      default: return 64'hx;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_(string tag, int s, logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, obs(x.sig), x.exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
    check_now();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic d0(logic [63:0] p, logic [31:0] i,
                    logic uv, logic [63:0] up, logic ut);
    b0.pc        = p;
    b0.ir        = i;
    b0.stall     = 1'b0;
    b0.upd_valid = uv;
    b0.upd_pc    = up;
    b0.upd_ghr   = 1'b0;
    b0.upd_taken = ut;
    b0.upd_miss  = 1'b0;
  endtask

  task automatic d1(logic [63:0] p, logic [31:0] i,
                    logic st, logic uv, logic [63:0] up,
                    logic [3:0] ug, logic ut, logic um);
    b1.pc        = p;
    b1.ir        = i;
    b1.stall     = st;
    b1.upd_valid = uv;
    b1.upd_pc    = up;
    b1.upd_ghr   = ug;
    b1.upd_taken = ut;
    b1.upd_miss  = um;
  endtask

  int sat_ut[11] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2};
  int sat_pr[11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    d0(64'h100, BEQ, 1'b0, 64'h0, 1'b0);
    d1(64'h0, NOP, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);

    // held in reset: predictions gated, addresses live
    expect_("rst_pr", 0, 0);
    expect_("rst_ghr1", 5, 0);
    smp();
    d0(64'h1000, 32'h0100_006F, 1'b0, 64'h0, 1'b0);
    #1;
    expect_("rst_jal", 2, 0);
    expect_("rst_jaddr", 3, 64'h1010);
    check_now();
    #1 rst_n = 1'b1;

    nxt();
    d0(64'h100, BEQ, 1'b0, 64'h0, 1'b0);
    expect_("t1_pr", 0, 0);
    expect_("t1_offs", 1, 0);
    expect_("t1_jal", 2, 0);
    expect_("t1_ghr0", 6, 0);
    smp();

    // saturation walk on index 0
    for (int k = 0; k < 11; k++) begin
      nxt();
      d0(64'h100, BEQ, sat_ut[k] != 2, 64'h100,
         sat_ut[k] == 1);
      expect_($sformatf("sat%0d", k), 0, 64'(sat_pr[k]));
      smp();
    end

    nxt();
    d0(64'h200, BEQ, 1'b0, 64'h0, 1'b0);
    expect_("alias_200", 0, 1);
    smp();
    nxt();
    d0(64'h104, BEQ, 1'b0, 64'h0, 1'b0);
    expect_("alias_104", 0, 0);
    smp();

    nxt();
    d0(64'h104, 32'h0000_0463, 1'b0, 64'h0, 1'b0);
    expect_("offs_p8", 1, 64'h8);
    smp();
    nxt();
    d0(64'h104, 32'h8000_0063, 1'b0, 64'h0, 1'b0);
    expect_("offs_neg", 1, 64'h1000);
    smp();

    nxt();
    d0(64'h1000, 32'h0100_006F, 1'b0, 64'h0, 1'b0);
    expect_("jal_tk", 2, 1);
    expect_("jal_a1", 3, 64'h1010);
    expect_("jal_pr", 0, 0);
    expect_("jal_offs", 1, 0);
    smp();
    nxt();
    d0(64'h1000, 32'hFF1F_F06F, 1'b0, 64'h0, 1'b0);
    expect_("jal_a2", 3, 64'h0FF0);
    smp();

    // collision: write to the index being read
    nxt();
    d0(64'h108, BEQ, 1'b1, 64'h108, 1'b1);
    expect_("coll_now", 0, 0);
    smp();
    nxt();
    d0(64'h108, BEQ, 1'b0, 64'h0, 1'b0);
    expect_("coll_next", 0, 1);
    smp();
    #1 rst_n = 1'b0;
    #1;
    expect_("async_pr", 0, 0);
    check_now();
    #1 rst_n = 1'b1;
    nxt();
    d0(64'h108, BEQ, 1'b1, 64'h108, 1'b1);
    expect_("post_rst", 0, 0);
    smp();
    nxt();
    d0(64'h108, BEQ, 1'b0, 64'h0, 1'b0);
    expect_("post_rst2", 0, 1);
    smp();

    // gshare instance
    d0(64'h0, NOP, 1'b0, 64'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nxt();
      d1(64'h100, NOP, 1'b0, 1'b1, 64'h100, 4'h0, 1'b1,
         1'b0);
      expect_("g_train", 5, 0);
      smp();
    end
    for (int k = 0; k < 2; k++) begin
      nxt();
      d1(64'h100, BEQ, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
      expect_("g_stall_pr", 4, 1);
      expect_("g_stall_ghr", 5, 0);
      smp();
    end
    nxt();
    d1(64'h100, BEQ, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    expect_("g_go_ghr", 5, 0);
    smp();
    nxt();
    d1(64'h108, BEQ, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    expect_("g_shift1", 5, 4'b0001);
    expect_("g_nt_pr", 4, 0);
    smp();
    nxt();
    d1(64'h108, BEQ, 1'b0, 1'b1, 64'h300, 4'b0101, 1'b1,
       1'b1);
    expect_("g_shift0", 5, 4'b0010);
    expect_("g_xor_pr", 4, 1);
    smp();
    nxt();
    d1(64'h38, BEQ, 1'b1, 1'b1, 64'h300, 4'b0101, 1'b0,
       1'b0);
    expect_("g_repair", 5, 4'b1011);
    expect_("g_wr_idx", 4, 1);
    smp();
    nxt();
    d1(64'h38, BEQ, 1'b1, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0);
    expect_("g_nomiss", 5, 4'b1011);
    expect_("g_dec", 4, 0);
    smp();

    $display("Result: errors=%0d of %0d checks", errors,
             checks);
    $finish;
  end
endmodule
